// File: rtl/scan_bist_pkg.sv
// rtl/scan_bist_pkg.sv - shared types and constants for the scan BIST controller
//
// Purpose: FSM state encoding, Galois polynomial mask and the default
//          parameter values used by scan_bist_ctrl and bist_step32.
// Ports:   none (package).
package scan_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SHIFT,
    ST_CAPTURE,
    ST_FLUSH,
    ST_COMPARE,
    ST_DONE
  } bistState_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] POLY_MASK = 32'h8020_0003;

  localparam int          DEF_CHAIN_LEN    = 18;
  localparam int          DEF_PI_W         = 14;
  localparam int          DEF_PO_W         = 14;
  localparam int          DEF_NUM_PATTERNS = 300;
  localparam logic [31:0] DEF_SEED         = 32'h1;

endpackage

// File: rtl/bist_step32.sv
// rtl/bist_step32.sv - one combinational step of a 32-bit Galois LFSR/MISR
//
// Purpose: shifts the register right by one, folds the polynomial mask in
//          when bit 0 falls out, then XORs an optional input word.
// Ports:   stateIn  in  32  current register value
//          xorIn    in  32  word folded into the result (zero for a plain LFSR)
//          stateOut out 32  next register value
module bist_step32
  import scan_bist_pkg::*;
(
  input  logic [31:0] stateIn,
  input  logic [31:0] xorIn,
  output logic [31:0] stateOut
);

  assign stateOut = {1'b0, stateIn[31:1]} ^ (stateIn[0] ? POLY_MASK : 32'h0) ^ xorIn;

endmodule

// File: rtl/scan_bist_ctrl.sv
// rtl/scan_bist_ctrl.sv - pseudo-random scan BIST controller with MISR compaction
//
// Purpose: drives LFSR patterns into a CUT scan chain and primary inputs,
//          compacts the unloaded chain and primary outputs into a MISR and
//          compares the final signature against golden_sig.
// Ports:   CK, RST (async, active-high)   clock / reset
//          start, abort                   run request / cancel
//          golden_sig [31:0]              expected final signature
//          scan_out, po [PO_W-1:0]        CUT responses
//          scan_en, scan_in, pi [PI_W-1:0] CUT stimulus
//          busy, done, pass               status
//          signature [31:0]               live MISR value
//          pat_cnt                        patterns completed
module scan_bist_ctrl
  import scan_bist_pkg::*;
#(
  parameter int          CHAIN_LEN    = DEF_CHAIN_LEN,
  parameter int          PI_W         = DEF_PI_W,
  parameter int          PO_W         = DEF_PO_W,
  parameter int          NUM_PATTERNS = DEF_NUM_PATTERNS,
  parameter logic [31:0] SEED         = DEF_SEED
) (
  input  logic                              CK,
  input  logic                              RST,
  input  logic                              start,
  input  logic                              abort,
  input  logic [31:0]                       golden_sig,
  input  logic                              scan_out,
  input  logic [PO_W-1:0]                   po,
  output logic                              scan_en,
  output logic                              scan_in,
  output logic [PI_W-1:0]                   pi,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [31:0]                       signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0] pat_cnt
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(NUM_PATTERNS + 1);

  bistState_t    state, stateNext;
  logic [31:0]   lfsr, lfsrNext;
  logic [31:0]   misr, misrNext, misrIn;
  logic [SW-1:0] shCnt;
  logic [CW-1:0] patCnt, patCntInc;
  logic [PI_W-1:0] piReg;
  logic          passReg;
  logic          lastShift;

  bist_step32 uLfsrStep (.stateIn(lfsr), .xorIn(32'h0),  .stateOut(lfsrNext));
  bist_step32 uMisrStep (.stateIn(misr), .xorIn(misrIn), .stateOut(misrNext));

  assign patCntInc = patCnt + 1'b1;
  assign lastShift = (shCnt == SW'(CHAIN_LEN - 1));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    misrIn    = 32'h0;
    case (state)
      ST_IDLE, ST_DONE: if (start) stateNext = ST_SEED;
      ST_SEED:          stateNext = ST_SHIFT;
      ST_SHIFT: begin
        scan_en = 1'b1;
        scan_in = lfsr[0];
        misrIn  = {31'b0, scan_out};
        if (lastShift) stateNext = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        misrIn    = 32'(po);
        // patCnt only reaches its new value at the end of this cycle
        stateNext = (patCntInc == CW'(NUM_PATTERNS)) ? ST_FLUSH : ST_SHIFT;
      end
      ST_FLUSH: begin
        scan_en = 1'b1;
        misrIn  = {31'b0, scan_out};
        if (lastShift) stateNext = ST_COMPARE;
      end
      ST_COMPARE:       stateNext = ST_DONE;
      default:          stateNext = ST_IDLE;
    endcase
    if (abort) stateNext = ST_IDLE;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      lfsr    <= SEED;
      misr    <= 32'h0;
      patCnt  <= '0;
      shCnt   <= '0;
      piReg   <= '0;
      passReg <= 1'b0;
    end else if (abort) begin
      passReg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) passReg <= 1'b0;
        ST_SEED: begin
          lfsr   <= SEED;
          misr   <= 32'h0;
          patCnt <= '0;
          shCnt  <= '0;
        end
        ST_SHIFT: begin
          lfsr  <= lfsrNext;
          // first unload carries the CUT's unknown pre-run state
          if (patCnt != '0) misr <= misrNext;
          shCnt <= lastShift ? '0 : shCnt + 1'b1;
          if (lastShift) piReg <= lfsrNext[PI_W-1:0];
        end
        ST_CAPTURE: begin
          misr   <= misrNext;
          patCnt <= patCntInc;
          shCnt  <= '0;
        end
        ST_FLUSH: begin
          misr  <= misrNext;
          shCnt <= lastShift ? '0 : shCnt + 1'b1;
        end
        ST_COMPARE: passReg <= (misr == golden_sig);
        default: ;
      endcase
    end
  end

  assign pi        = piReg;
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign pass      = passReg;
  assign signature = misr;
  assign pat_cnt   = patCnt;

endmodule

// File: doc/scan_bist_ctrl.md
SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 18, the number of scan flops in the CUT chain.
REQ-002 SHALL have parameter PI_W, default 14, the CUT primary-input width (1..32).
REQ-003 SHALL have parameter PO_W, default 14, the CUT primary-output width (1..32).
REQ-004 SHALL have parameter NUM_PATTERNS, default 300, the number of pseudo-random patterns per run (>=1).
REQ-005 SHALL have parameter SEED, default 32'h1, the LFSR start value (nonzero).
REQ-006 SHALL have port CK  in  1  clock; all state updates on the rising edge.
REQ-007 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  in  1  run request; sampled in IDLE or DONE only.
REQ-009 SHALL have port abort  in  1  cancel the run; the block returns to IDLE.
REQ-010 SHALL have port golden_sig  in  32  expected final MISR value.
REQ-011 SHALL have port scan_out  in  1  CUT chain tail.
REQ-012 SHALL have port po  in  PO_W  CUT primary outputs.
REQ-013 SHALL have port scan_en  out  1  CUT shift enable.
REQ-014 SHALL have port scan_in  out  1  CUT chain head.
REQ-015 SHALL have port pi  out  PI_W  CUT primary inputs.
REQ-016 SHALL have ports busy, done, pass  out  1 each  status flags.
REQ-017 SHALL have port signature  out  32  current MISR value.
REQ-018 SHALL have port pat_cnt  out  $clog2(NUM_PATTERNS+1)  number of patterns completed.

Function
REQ-019 SHALL implement the FSM states IDLE, SEED, SHIFT, CAPTURE, FLUSH, COMPARE and DONE.
REQ-020 IDLE/DONE + start=1: go to SEED; done and pass clear; busy=1 from the next cycle.
REQ-021 SEED (1 cycle): LFSR<=SEED, MISR<=0, pat_cnt<=0, shift counter<=0; next state SHIFT.
REQ-022 SHIFT: scan_en=1 and scan_in=LFSR[0] for exactly CHAIN_LEN cycles; the LFSR steps each cycle; next state CAPTURE.
REQ-023 SHIFT with pat_cnt>0: MISR<=step(MISR) XOR {31'b0,scan_out}; with pat_cnt==0 the MISR holds (unload of unknown reset state ignored).
REQ-024 CAPTURE (1 cycle): scan_en=0; MISR<=step(MISR) XOR zero-extended po; pat_cnt increments.
REQ-025 pi SHALL equal LFSR[PI_W-1:0], registered at SHIFT exit and held stable through CAPTURE.
REQ-026 After CAPTURE: if pat_cnt==NUM_PATTERNS go to FLUSH, else go to SHIFT with the shift counter cleared.
REQ-027 FLUSH: CHAIN_LEN cycles with scan_en=1, scan_in=0, MISR absorbing scan_out as in SHIFT; next state COMPARE.
REQ-028 COMPARE (1 cycle): pass<=(MISR==golden_sig); next state DONE.
REQ-029 DONE: done=1, busy=0, pass and signature held until start, abort or RST.
REQ-030 LFSR and MISR step function SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps mask 32'h8020_0003), shift right, feedback from bit 0.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort SHALL take priority over start in the same cycle; any state goes to IDLE; done=pass=0; MISR and pat_cnt hold.
REQ-033 In IDLE: scan_en=0, scan_in=0, pi held at the last value.
REQ-034 Run length SHALL be exactly 1+NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles from start to done.

Reset
REQ-035 RST=1 SHALL immediately force state IDLE, scan_en=0, scan_in=0, pi=0, busy=done=pass=0, signature=0, pat_cnt=0, LFSR=SEED, including mid-run.

Structure
REQ-036 Package scan_bist_pkg SHALL hold the state enum, the polynomial mask constant and the default parameter values.
REQ-037 A sub-module bist_step32 (combinational Galois step with optional XOR-in) SHALL be instantiated twice, once for the LFSR and once for the MISR.

Verification
REQ-038 CHAIN_LEN=4, NUM_PATTERNS=2, start pulse -> done rises exactly 16 cycles later; scan_en high 4+4+4 cycles total.
REQ-039 CUT model = 4-bit shift register plus po=pi, golden_sig from the bench reference model -> pass=1; golden_sig bit 0 flipped -> pass=0.
REQ-040 Stuck-at-0 forced on scan_out, golden_sig computed fault-free -> pass=0, signature differs.
REQ-041 abort asserted during the second SHIFT -> IDLE next cycle, done=0; a new start then completes normally with the same signature.
REQ-042 RST pulsed mid-CAPTURE -> all outputs reach their reset values asynchronously; start during busy -> no restart, cycle count unchanged.
